// File: rtl/wishbone_burst_master_if.sv
// Wishbone classic bus bundle shared by the burst master and its slave.
// Signals:
//   cyc, stb, we - cycle, strobe, write enable (master -> slave)
//   adr          - byte address (master -> slave)
//   dat_w, sel   - write data and byte select (master -> slave)
//   ack, err     - beat termination (slave -> master)
//   dat_r        - read data (slave -> master)
interface rggen_wishbone_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wishbone_burst_master.sv
// Wishbone burst master: runs an incrementing-address read or write burst of
// up to MAX_BEATS beats, one classic cycle per beat, with cyc held for the
// whole burst. Write data arrives on a valid/ready stream, read data leaves on
// a valid/ready stream.
// Ports:
//   clk, i_rst_n                  - clock, asynchronous active-low reset
//   i_start/i_we/i_addr/i_len/i_sel - burst command
//   i_wdata/i_wvalid/o_wready     - write-data stream into the master
//   o_rdata/o_rvalid/i_rready     - read-data stream out of the master
//   o_busy/o_done/o_err/o_timeout/o_beats - burst status
//   wb_if                         - Wishbone master side
module wishbone_burst_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_BEATS      = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int LEN_W         = $clog2(MAX_BEATS + 1),
  localparam int STEP          = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [LEN_W-1:0]        i_len,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic                    o_timeout,
  output logic [LEN_W-1:0]        o_beats,
  rggen_wishbone_if.master        wb_if
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0]      MAX_LEN  = LEN_W'(MAX_BEATS);
  localparam logic [ADDR_WIDTH-1:0] ADR_INC  = ADDR_WIDTH'(STEP);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] beats_next;

  assign eff_len    = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign beats_next = o_beats + 1'b1;

  // All outputs are registered; each transition sets them to the values of
  // the state being entered, so a state's outputs are valid for its whole stay.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      tmo_cnt_reg  <= '0;
      wb_if.cyc    <= 1'b0;
      wb_if.stb    <= 1'b0;
      wb_if.we     <= 1'b0;
      wb_if.adr    <= '0;
      wb_if.dat_w  <= '0;
      wb_if.sel    <= '0;
      o_wready     <= 1'b0;
      o_rdata      <= '0;
      o_rvalid     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
      o_beats      <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            wb_if.we    <= i_we;
            wb_if.adr   <= i_addr;
            wb_if.sel   <= i_sel;
            len_reg     <= eff_len;
            o_err       <= 1'b0;
            o_timeout   <= 1'b0;
            o_beats     <= '0;
            o_busy      <= 1'b1;
            tmo_cnt_reg <= '0;
            if (eff_len == '0) begin
              // Empty burst: report completion without touching the bus.
              state_reg <= DONE;
              o_done    <= 1'b1;
            end else if (i_we) begin
              state_reg <= WDATA;
              wb_if.cyc <= 1'b1;
              o_wready  <= 1'b1;
            end else begin
              state_reg <= REQ;
              wb_if.cyc <= 1'b1;
              wb_if.stb <= 1'b1;
            end
          end
        end

        WDATA: begin
          if (i_wvalid) begin
            wb_if.dat_w <= i_wdata;
            o_wready    <= 1'b0;
            wb_if.stb   <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= REQ;
          end
        end

        REQ: begin
          if (wb_if.err) begin
            // err wins over a simultaneous ack; the beat is not counted.
            o_err     <= 1'b1;
            wb_if.stb <= 1'b0;
            wb_if.cyc <= 1'b0;
            o_done    <= 1'b1;
            state_reg <= DONE;
          end else if (wb_if.ack) begin
            o_beats   <= beats_next;
            wb_if.stb <= 1'b0;
            if (!wb_if.we) begin
              o_rdata   <= wb_if.dat_r;
              o_rvalid  <= 1'b1;
              state_reg <= RESP;
            end else if (beats_next == len_reg) begin
              wb_if.cyc <= 1'b0;
              o_done    <= 1'b1;
              state_reg <= DONE;
            end else begin
              wb_if.adr <= wb_if.adr + ADR_INC;
              o_wready  <= 1'b1;
              state_reg <= WDATA;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            o_timeout <= 1'b1;
            wb_if.stb <= 1'b0;
            wb_if.cyc <= 1'b0;
            o_done    <= 1'b1;
            state_reg <= DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        RESP: begin
          if (i_rready) begin
            o_rvalid <= 1'b0;
            // o_beats already counts the beat just delivered.
            if (o_beats == len_reg) begin
              wb_if.cyc <= 1'b0;
              o_done    <= 1'b1;
              state_reg <= DONE;
            end else begin
              wb_if.adr   <= wb_if.adr + ADR_INC;
              wb_if.stb   <= 1'b1;
              tmo_cnt_reg <= '0;
              state_reg   <= REQ;
            end
          end
        end

        DONE: begin
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_burst_master.sv
module tb_wishbone_burst_master;
  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_we;
  logic [31:0] i_addr;
  logic [4:0]  i_len;
  logic [3:0]  i_sel;
  logic [31:0] i_wdata;
  logic        i_wvalid;
  logic        o_wready;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        i_rready;
  logic        o_busy, o_done, o_err, o_timeout;
  logic [4:0]  o_beats;

  rggen_wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  wishbone_burst_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BEATS(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_we(i_we),
    .i_addr(i_addr), .i_len(i_len), .i_sel(i_sel),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout),
    .o_beats(o_beats), .wb_if(wb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // slave / stream model settings
  int          ack_lat = 2;
  int          err_beat = 99;
  bit          no_resp = 0;
  int          stall_beat = 99;
  int          stall_left = 0;
  logic [31:0] wr_base = 32'h0;
  logic [31:0] rd_base = 32'h0;

  // monitor state
  int          wait_cnt = 0;
  int          beat_n, wr_n, rd_n, stb_cyc, cyc_cyc, done_cnt, cyc_in_done;
  int          rvalid_cnt, stall_bad;
  bit          rvalid_q;
  logic [31:0] beat_adr [0:31];
  logic [31:0] beat_dat [0:31];
  logic [31:0] rd_log   [0:31];

  task automatic clr();
    beat_n = 0; wr_n = 0; rd_n = 0; stb_cyc = 0; cyc_cyc = 0; done_cnt = 0;
    cyc_in_done = 0; rvalid_cnt = 0; stall_bad = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave, write-stream source and read-stream sink, all acting on the falling edge.
  always @(negedge clk) begin
    if (o_done) begin
      done_cnt++;
      if (wb.cyc) cyc_in_done++;
    end
    if (wb.stb) stb_cyc++;
    if (wb.cyc) cyc_cyc++;
    if (o_rvalid && !rvalid_q) rvalid_cnt++;
    rvalid_q = o_rvalid;

    if (wb.cyc && wb.stb && !no_resp && i_rst_n) begin
      wait_cnt++;
      if (wait_cnt == ack_lat) begin
        wb.ack   = 1'b1;
        wb.err   = (beat_n == err_beat);
        wb.dat_r = rd_base + 32'(beat_n);
        if (beat_n < 32) begin
          beat_adr[beat_n] = wb.adr;
          beat_dat[beat_n] = wb.dat_w;
        end
        beat_n++;
      end else begin
        wb.ack = 1'b0;
        wb.err = 1'b0;
      end
    end else begin
      wb.ack = 1'b0;
      wb.err = 1'b0;
      wait_cnt = 0;
    end

    if (o_wready) begin
      i_wvalid = 1'b1;
      i_wdata  = wr_base + 32'(wr_n);
      wr_n++;
    end else begin
      i_wvalid = 1'b0;
    end

    if (o_rvalid) begin
      if (rd_n == stall_beat && stall_left > 0) begin
        i_rready = 1'b0;
        stall_left--;
        if (wb.stb || !wb.cyc) stall_bad++;
      end else begin
        i_rready = 1'b1;
        if (rd_n < 32) rd_log[rd_n] = o_rdata;
        rd_n++;
      end
    end else begin
      i_rready = 1'b1;
    end
  end

  task automatic start(input logic we, input logic [31:0] a, input logic [4:0] l);
    @(posedge clk);
    #1 clr();
    @(negedge clk);
    i_start = 1'b1; i_we = we; i_addr = a; i_len = l; i_sel = 4'hF;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k;
    k = 0;
    while (o_busy && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_we = 1'b0; i_addr = '0; i_len = '0;
    i_sel = '0; i_wdata = '0; i_wvalid = 1'b0; i_rready = 1'b1;
    wb.ack = 1'b0; wb.err = 1'b0; wb.dat_r = '0;
    clr();
    rvalid_q = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cyc",   {63'd0, wb.cyc}, 64'd0);
    check("rst_stb",   {63'd0, wb.stb}, 64'd0);
    check("rst_adr",   {32'd0, wb.adr}, 64'd0);
    check("rst_busy",  {63'd0, o_busy}, 64'd0);
    check("rst_wready",{63'd0, o_wready}, 64'd0);
    check("rst_beats", {59'd0, o_beats}, 64'd0);
    i_rst_n = 1'b1;

    // write burst: 4 beats, ack after 2 cycles
    ack_lat = 2; wr_base = 32'hA0;
    start(1'b1, 32'h1000, 5'd4);
    wait_idle(200, "wr_idle");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_adr%0d", i), {32'd0, beat_adr[i]}, 64'h1000 + 64'(4 * i));
      check($sformatf("wr_dat%0d", i), {32'd0, beat_dat[i]}, 64'hA0 + 64'(i));
    end
    check("wr_nbeats", 64'(beat_n), 64'd4);
    check("wr_beats",  {59'd0, o_beats}, 64'd4);
    check("wr_done",   64'(done_cnt), 64'd1);
    check("wr_err",    {63'd0, o_err}, 64'd0);
    check("wr_stbcyc", 64'(stb_cyc), 64'd8);

    // read burst: 3 beats, sink stalls 3 cycles on second beat
    ack_lat = 1; rd_base = 32'hDEADBEEF; stall_beat = 1; stall_left = 3;
    start(1'b0, 32'h2000, 5'd3);
    wait_idle(200, "rd_idle");
    check("rd_d0", {32'd0, rd_log[0]}, 64'hDEADBEEF);
    check("rd_d1", {32'd0, rd_log[1]}, 64'hDEADBEF0);
    check("rd_d2", {32'd0, rd_log[2]}, 64'hDEADBEF1);
    check("rd_adr2", {32'd0, beat_adr[2]}, 64'h2008);
    check("rd_stalled", 64'(stall_left), 64'd0);
    check("rd_stall_bus", 64'(stall_bad), 64'd0);
    check("rd_beats", {59'd0, o_beats}, 64'd3);
    check("rd_done", 64'(done_cnt), 64'd1);
    stall_beat = 99;

    // error on second beat of a 4-beat read
    err_beat = 1;
    start(1'b0, 32'h2000, 5'd4);
    wait_idle(200, "er_idle");
    check("er_err", {63'd0, o_err}, 64'd1);
    check("er_beats", {59'd0, o_beats}, 64'd1);
    check("er_rvalid", 64'(rvalid_cnt), 64'd1);
    check("er_done", 64'(done_cnt), 64'd1);
    check("er_cyc_done", 64'(cyc_in_done), 64'd0);
    check("er_tmo", {63'd0, o_timeout}, 64'd0);
    err_beat = 99;

    // timeout: slave never answers
    no_resp = 1;
    start(1'b0, 32'h100, 5'd2);
    wait_idle(100, "to_idle");
    check("to_stbcyc", 64'(stb_cyc), 64'd8);
    check("to_flag", {63'd0, o_timeout}, 64'd1);
    check("to_beats", {59'd0, o_beats}, 64'd0);
    check("to_done", 64'(done_cnt), 64'd1);
    check("to_err", {63'd0, o_err}, 64'd0);
    no_resp = 0;

    // zero length
    start(1'b1, 32'h500, 5'd0);
    check("z_done", {63'd0, o_done}, 64'd1);
    check("z_cyc", {63'd0, wb.cyc}, 64'd0);
    @(negedge clk);
    check("z_done_off", {63'd0, o_done}, 64'd0);
    check("z_busy", {63'd0, o_busy}, 64'd0);
    check("z_cyccnt", 64'(cyc_cyc), 64'd0);

    // oversize length saturates
    ack_lat = 1; wr_base = 32'h0;
    start(1'b1, 32'h0, 5'd21);
    wait_idle(400, "mx_idle");
    check("mx_nbeats", 64'(beat_n), 64'd16);
    check("mx_beats", {59'd0, o_beats}, 64'd16);
    check("mx_adr15", {32'd0, beat_adr[15]}, 64'h3C);

    // address wrap
    start(1'b1, 32'hFFFFFFFC, 5'd2);
    wait_idle(100, "wp_idle");
    check("wp_adr0", {32'd0, beat_adr[0]}, 64'hFFFFFFFC);
    check("wp_adr1", {32'd0, beat_adr[1]}, 64'h0);

    // start while busy is ignored
    ack_lat = 2;
    start(1'b1, 32'h3000, 5'd3);
    repeat (2) @(negedge clk);
    i_start = 1'b1; i_we = 1'b0; i_addr = 32'h5000; i_len = 5'd1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle(200, "bz_idle");
    repeat (3) @(negedge clk);
    check("bz_nbeats", 64'(beat_n), 64'd3);
    check("bz_adr2", {32'd0, beat_adr[2]}, 64'h3008);
    check("bz_done", 64'(done_cnt), 64'd1);
    check("bz_busy", {63'd0, o_busy}, 64'd0);

    // reset during beat 2 of a 4-beat write
    start(1'b1, 32'h4000, 5'd4);
    begin
      int k;
      k = 0;
      while (!(wb.stb && beat_n == 1) && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("rs_reach_beat2", 64'(beat_n), 64'd1);
    end
    #2 i_rst_n = 1'b0;
    #1;
    check("rs_cyc", {63'd0, wb.cyc}, 64'd0);
    check("rs_stb", {63'd0, wb.stb}, 64'd0);
    check("rs_busy", {63'd0, o_busy}, 64'd0);
    repeat (2) @(negedge clk);
    check("rs_nodone", 64'(done_cnt), 64'd0);
    i_rst_n = 1'b1;
    ack_lat = 1; rd_base = 32'h12345678;
    start(1'b0, 32'h10, 5'd1);
    wait_idle(100, "rs_idle");
    check("rs_rd", {32'd0, rd_log[0]}, 64'h12345678);
    check("rs_beats", {59'd0, o_beats}, 64'd1);
    check("rs_done", 64'(done_cnt), 64'd1);
    check("rs_err", {63'd0, o_err}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
